mix_columns_engine: RTL and testbench

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

---
 rtl/mix_columns_engine.sv | 144 ++++++++++++++
 tb/tb_mix_columns_engine.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
// AES MixColumns engine: one 32-bit column per cycle through an IDLE/BUSY/DONE handshake FSM.
// Optional macro MIX_COL_INV_EN adds the inv_mode port and the InvMixColumns datapath.
module mix_columns_engine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef MIX_COL_INV_EN
  ,
  input  logic         inv_mode
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] data_q, data_d;
  logic [127:0] out_q, out_d;
  logic [31:0]  data_col [4];
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    // 3a = xtime(a) ^ a
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIX_COL_INV_EN
  logic inv_q, inv_d;

  function automatic logic [31:0] mix_inv(input logic [31:0] w);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      a[j]  = w[31-8*j -: 8];
      x2    = xt(a[j]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[j] = x8 ^ a[j];
      mb[j] = x8 ^ x2 ^ a[j];
      md[j] = x8 ^ x4 ^ a[j];
      me[j] = x8 ^ x4 ^ x2;
    end
    // Each matrix row is the row above rotated right by one byte.
    r[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    r[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    r[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    r[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return r;
  endfunction
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign data_col[gi] = data_q[127-32*gi -: 32];
  end

  assign col_in = data_col[col_q];

`ifdef MIX_COL_INV_EN
  assign col_out = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
  assign col_out = mix_fwd(col_in);
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    out_d   = out_q;
`ifdef MIX_COL_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_state;
          col_d   = 2'd0;
          state_d = BUSY;
`ifdef MIX_COL_INV_EN
          inv_d   = inv_mode;
`endif
        end
      end
      BUSY: begin
        for (int i = 0; i < 4; i++) begin
          if (col_q == i[1:0]) out_d[127-32*i -: 32] = col_out;
        end
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= 128'h0;
      out_q   <= 128'h0;
`ifdef MIX_COL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
      out_q   <= out_d;
`ifdef MIX_COL_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_state = out_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine using FIPS-197 MixColumns vectors and hand-derived edge cases.
// Inverse-mode vectors run only when MIX_COL_INV_EN is defined.
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
`ifdef MIX_COL_INV_EN
  logic         inv_mode;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mix_columns_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state)
`ifdef MIX_COL_INV_EN
    ,
    .inv_mode (inv_mode)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
    $display("vec %0d %s: got %h want %h", n_vec, tag, obs, exp);
  endtask

  // Present a state for one accept edge.
  task automatic accept(input string tag, input logic [127:0] st, input logic inv);
    chk({tag, "_rdy"}, {127'h0, in_ready}, 128'h1);
    in_valid = 1'b1;
    in_state = st;
`ifdef MIX_COL_INV_EN
    inv_mode = inv;
`else
    if (inv) $display("inverse request ignored in forward-only build");
`endif
    step();
    in_valid = 1'b0;
    in_state = 128'h0;
  endtask

  // Wait (bounded) for out_valid, check latency and result, then let DONE hand off.
  task automatic finish_op(input string tag, input logic [127:0] exp);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'd4);
    chk({tag, "_res"}, out_state, exp);
    step();
  endtask

  task automatic run(input string tag, input logic [127:0] st, input logic inv,
                     input logic [127:0] exp);
    accept(tag, st, inv);
    step();
    finish_op(tag, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = 128'h0;
    out_ready = 1'b1;
`ifdef MIX_COL_INV_EN
    inv_mode  = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;
    chk("rst_ready", {127'h0, in_ready}, 128'h1);
    chk("rst_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_out", out_state, 128'h0);

    // FIPS-197 forward vector, then 10 cycles of backpressure in DONE
    out_ready = 1'b0;
    accept("fips", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    step();
    begin
      int lat;
      lat = 1;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      chk("fips_lat", 128'(lat), 128'd4);
    end
    chk("fips_res", out_state, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", {out_valid, in_ready, out_state},
          {1'b1, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6});
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", {126'h0, out_valid, in_ready}, 128'h1);

    // Only column 0 is rewritten after the first BUSY edge
    accept("part", 128'h0, 1'b0);
    step();
    chk("part_col0", out_state, 128'h00000000_9fdc589d_01010101_c6c6c6c6);
    finish_op("zero", 128'h0);

    run("ones", {128{1'b1}}, 1'b0, {128{1'b1}});
    run("fips2", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
        128'h046681e5_e0cb199a_48f8d37a_2806264c);

    // A second in_valid while BUSY must not disturb the running operation
    accept("ign", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    in_valid = 1'b1;
    in_state = {128{1'b1}};
    step();
    in_valid = 1'b0;
    in_state = 128'h0;
    finish_op("ign", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

    // Reset while col = 2 abandons the operation
    accept("mid", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst", {out_valid, in_ready, out_state}, {1'b0, 1'b1, 128'h0});
    run("after_rst", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
        128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

`ifdef MIX_COL_INV_EN
    run("inv1", 128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1,
        128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    run("inv2", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
        128'hdb135345_f20a225c_01010101_c6c6c6c6);
    run("inv_ones", {128{1'b1}}, 1'b1, {128{1'b1}});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
